// File: rtl/miter_seq_monitor_if.sv
// Bundle for the sequential miter: pattern-result inputs and campaign outputs.
// The master drives the campaign controls and pattern results; the slave is the monitor.
interface miter_seq_monitor_if #(
  parameter int unsigned N_OUT = 2,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop_on_fail;
  logic [CNT_W-1:0] num_pat;
  logic             in_valid;
  logic [N_OUT-1:0] org_out;
  logic [N_OUT-1:0] enc_out;
  logic [N_OUT-1:0] Q;
  logic             Z;
  logic [N_OUT-1:0] sticky_mis;
  logic [CNT_W-1:0] mis_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [CNT_W-1:0] pat_cnt;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    output start, stop_on_fail, num_pat, in_valid, org_out, enc_out,
    input  Q, Z, sticky_mis, mis_cnt, first_fail_idx, pat_cnt, busy, done, pass
  );

  modport slave (
    input  start, stop_on_fail, num_pat, in_valid, org_out, enc_out,
    output Q, Z, sticky_mis, mis_cnt, first_fail_idx, pat_cnt, busy, done, pass
  );
endinterface

// File: rtl/miter_seq_monitor.sv
// Clocked original-vs-locked miter: registers per-output equality for each valid
// pattern and accumulates a campaign verdict over a programmed number of patterns.
module miter_seq_monitor #(
  parameter int unsigned N_OUT = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic                   C,
  input logic                   R,
  miter_seq_monitor_if.slave    bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [N_OUT-1:0] q_q;
  logic             z_q;
  logic [N_OUT-1:0] sticky_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic [CNT_W-1:0] ffi_q;
  logic [CNT_W-1:0] pat_cnt_q;
  logic             pass_q;
  logic             stop_q;
  logic [CNT_W-1:0] num_q;

  logic [N_OUT-1:0] diff;
  logic             mismatch;
  logic [CNT_W-1:0] pat_inc;
  logic             last_pat;

  always_comb begin
    diff     = bus_io.org_out ^ bus_io.enc_out;
    mismatch = |diff;
    pat_inc  = pat_cnt_q + CNT_W'(1);
    last_pat = (pat_inc == num_q);
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q   <= StIdle;
      q_q       <= '1;
      z_q       <= 1'b1;
      sticky_q  <= '0;
      mis_cnt_q <= '0;
      ffi_q     <= '0;
      pat_cnt_q <= '0;
      pass_q    <= 1'b0;
      stop_q    <= 1'b0;
      num_q     <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus_io.start) begin
            q_q       <= '1;
            z_q       <= 1'b1;
            sticky_q  <= '0;
            mis_cnt_q <= '0;
            ffi_q     <= '0;
            pat_cnt_q <= '0;
            num_q     <= bus_io.num_pat;
            stop_q    <= bus_io.stop_on_fail;
            // An empty campaign trivially passes.
            if (bus_io.num_pat == '0) begin
              state_q <= StDone;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              pass_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (bus_io.in_valid) begin
            q_q       <= ~diff;
            z_q       <= ~mismatch;
            pat_cnt_q <= pat_inc;
            if (mismatch) begin
              sticky_q <= sticky_q | diff;
              if (!(&mis_cnt_q)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
              if (mis_cnt_q == '0) ffi_q <= pat_cnt_q;
            end
            if (mismatch && stop_q) begin
              state_q <= StDone;
              pass_q  <= 1'b0;
            end else if (last_pat) begin
              state_q <= StDone;
              pass_q  <= (mis_cnt_q == '0) && !mismatch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.Q              = q_q;
  assign bus_io.Z              = z_q;
  assign bus_io.sticky_mis     = sticky_q;
  assign bus_io.mis_cnt        = mis_cnt_q;
  assign bus_io.first_fail_idx = ffi_q;
  assign bus_io.pat_cnt        = pat_cnt_q;
  assign bus_io.busy           = (state_q == StRun);
  assign bus_io.done           = (state_q == StDone);
  assign bus_io.pass           = pass_q;

endmodule

// File: tb/tb_miter_seq_monitor.sv
// Scoreboard bench for miter_seq_monitor: directed campaigns on a 2-bit/16-bit
// instance plus a saturation run on an 8-bit/4-bit instance.
module tb_miter_seq_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  miter_seq_monitor_if #(.N_OUT(2), .CNT_W(16)) b2 ();
  miter_seq_monitor_if #(.N_OUT(8), .CNT_W(4))  b8 ();

  miter_seq_monitor #(.N_OUT(2), .CNT_W(16)) dut2 (.C(clk), .R(rst_n), .bus_io(b2));
  miter_seq_monitor #(.N_OUT(8), .CNT_W(4))  dut8 (.C(clk), .R(rst_n), .bus_io(b8));

  typedef struct {
    int          id;
    int          due;
    logic [1:0]  q;
    logic        z;
    logic [1:0]  st;
    logic [15:0] mis;
    logic [15:0] ffi;
    logic [15:0] pat;
    logic        busy;
    logic        done;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic step(input logic st, input logic sof, input logic [15:0] num, input logic v,
                      input logic [1:0] org, input logic [1:0] enc);
    @(posedge clk);
    #1;
    b2.start        = st;
    b2.stop_on_fail = sof;
    b2.num_pat      = num;
    b2.in_valid     = v;
    b2.org_out      = org;
    b2.enc_out      = enc;
  endtask

  task automatic step8(input logic st, input logic [3:0] num, input logic v,
                       input logic [7:0] org, input logic [7:0] enc);
    @(posedge clk);
    #1;
    b8.start        = st;
    b8.stop_on_fail = 1'b0;
    b8.num_pat      = num;
    b8.in_valid     = v;
    b8.org_out      = org;
    b8.enc_out      = enc;
  endtask

  // Expected outputs after the edge that consumes the most recent step.
  task automatic expect_s(input logic [1:0] q, input logic z, input logic [1:0] st,
                          input int mis, input int ffi, input int pat,
                          input logic busy, input logic done, input logic pass);
    exp_t e;
    e.id   = nid;
    nid++;
    e.due  = cyc + 1;
    e.q    = q;
    e.z    = z;
    e.st   = st;
    e.mis  = 16'(mis);
    e.ffi  = 16'(ffi);
    e.pat  = 16'(pat);
    e.busy = busy;
    e.done = done;
    e.pass = pass;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      cmp($sformatf("v%0d.Q", mon_e.id), 32'(b2.Q), 32'(mon_e.q));
      cmp($sformatf("v%0d.Z", mon_e.id), 32'(b2.Z), 32'(mon_e.z));
      cmp($sformatf("v%0d.sticky", mon_e.id), 32'(b2.sticky_mis), 32'(mon_e.st));
      cmp($sformatf("v%0d.mis_cnt", mon_e.id), 32'(b2.mis_cnt), 32'(mon_e.mis));
      cmp($sformatf("v%0d.ffi", mon_e.id), 32'(b2.first_fail_idx), 32'(mon_e.ffi));
      cmp($sformatf("v%0d.pat_cnt", mon_e.id), 32'(b2.pat_cnt), 32'(mon_e.pat));
      cmp($sformatf("v%0d.busy", mon_e.id), 32'(b2.busy), 32'(mon_e.busy));
      cmp($sformatf("v%0d.done", mon_e.id), 32'(b2.done), 32'(mon_e.done));
      cmp($sformatf("v%0d.pass", mon_e.id), 32'(b2.pass), 32'(mon_e.pass));
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) cmp("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset2(input string tag);
    cmp({tag, ".Q"}, 32'(b2.Q), 32'h3);
    cmp({tag, ".Z"}, 32'(b2.Z), 32'h1);
    cmp({tag, ".sticky"}, 32'(b2.sticky_mis), 32'h0);
    cmp({tag, ".mis_cnt"}, 32'(b2.mis_cnt), 32'h0);
    cmp({tag, ".ffi"}, 32'(b2.first_fail_idx), 32'h0);
    cmp({tag, ".pat_cnt"}, 32'(b2.pat_cnt), 32'h0);
    cmp({tag, ".busy"}, 32'(b2.busy), 32'h0);
    cmp({tag, ".done"}, 32'(b2.done), 32'h0);
    cmp({tag, ".pass"}, 32'(b2.pass), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    b2.start = 1'b0; b2.stop_on_fail = 1'b0; b2.num_pat = '0;
    b2.in_valid = 1'b0; b2.org_out = '0; b2.enc_out = '0;
    b8.start = 1'b0; b8.stop_on_fail = 1'b0; b8.num_pat = '0;
    b8.in_valid = 1'b0; b8.org_out = '0; b8.enc_out = '0;

    #8;
    check_reset2("rst");
    cmp("rst8.Q", 32'(b8.Q), 32'hFF);
    #4;
    rst_n = 1'b1;

    // Idle, then in_valid outside RUN is ignored
    step(0, 0, 0, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2);           expect_s(3, 1, 0, 0, 0, 0, 0, 0, 0);
    // Empty campaign
    step(1, 0, 0, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 0, 1, 1);

    // Four matching patterns
    step(1, 0, 4, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);           expect_s(3, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1);           expect_s(3, 1, 0, 0, 0, 2, 1, 0, 0);
    step(0, 0, 0, 1, 2, 2);           expect_s(3, 1, 0, 0, 0, 3, 1, 0, 0);
    step(0, 0, 0, 1, 3, 3);           expect_s(3, 1, 0, 0, 0, 4, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 4, 0, 1, 1);

    // Five patterns, mismatches on 1 (bit0) and 3 (bit1)
    step(1, 0, 5, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 2, 2);           expect_s(3, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);           expect_s(2, 0, 1, 1, 1, 2, 1, 0, 0);
    step(0, 0, 0, 1, 3, 3);           expect_s(3, 1, 1, 1, 1, 3, 1, 0, 0);
    step(0, 0, 0, 1, 2, 0);           expect_s(1, 0, 3, 2, 1, 4, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);           expect_s(3, 1, 3, 2, 1, 5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);           expect_s(3, 1, 3, 2, 1, 5, 0, 1, 0);

    // Stop on first fail at pattern 2; later in_valid pulses ignored
    step(1, 1, 10, 0, 0, 0);          expect_s(3, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1);           expect_s(3, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 2, 2);           expect_s(3, 1, 0, 0, 0, 2, 1, 0, 0);
    step(0, 0, 0, 1, 3, 0);           expect_s(0, 0, 3, 1, 2, 3, 0, 1, 0);
    step(0, 0, 0, 1, 0, 3);           expect_s(0, 0, 3, 1, 2, 3, 0, 1, 0);
    step(0, 0, 0, 1, 1, 2);           expect_s(0, 0, 3, 1, 2, 3, 0, 1, 0);

    // Gaps and a start during RUN (num_pat=1 there must not be relatched)
    step(1, 0, 3, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 2, 2);           expect_s(3, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 2);           expect_s(3, 1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 3, 3);           expect_s(3, 1, 0, 0, 0, 2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3);           expect_s(3, 1, 0, 0, 0, 2, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1);           expect_s(3, 1, 0, 0, 0, 3, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 3, 0, 1, 1);
    drain();

    // Narrow variant: 15 mismatching patterns fill the 4-bit counters exactly
    step8(1, 4'hF, 0, 8'h00, 8'h00);
    for (int i = 0; i < 15; i++) step8(0, 4'h0, 1, 8'hA5, 8'h5A);
    step8(0, 4'h0, 0, 8'h00, 8'h00);
    @(negedge clk);
    cmp("n8.mis_cnt", 32'(b8.mis_cnt), 32'hF);
    cmp("n8.pat_cnt", 32'(b8.pat_cnt), 32'hF);
    cmp("n8.ffi", 32'(b8.first_fail_idx), 32'h0);
    cmp("n8.sticky", 32'(b8.sticky_mis), 32'hFF);
    cmp("n8.Q", 32'(b8.Q), 32'h00);
    cmp("n8.done", 32'(b8.done), 32'h1);
    cmp("n8.pass", 32'(b8.pass), 32'h0);

    // Asynchronous reset mid-RUN, then a clean campaign
    step(1, 0, 5, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 2);           expect_s(0, 0, 3, 1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);           expect_s(0, 0, 3, 1, 0, 1, 1, 0, 0);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset2("arst");
    #4;
    rst_n = 1'b1;
    step(1, 0, 1, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 2, 2);           expect_s(3, 1, 0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);           expect_s(3, 1, 0, 0, 0, 1, 0, 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
